// File: rtl/pipe_pkg.sv
// Shared definitions for the EX->MEM pipeline stage.
//   MOP_* : memory-op codes; MOP_NONE marks "no memory access", the rest are
//           decoded by the MEM stage.
//   ex_mem_payload_t : payload carried from EX to MEM at the default widths
//           (32-bit data, 5-bit register address, 3-bit mop).
package pipe_pkg;

    localparam int MOP_NONE = 0;
    localparam int MOP_LB   = 1;
    localparam int MOP_LH   = 2;
    localparam int MOP_LW   = 3;
    localparam int MOP_SB   = 4;
    localparam int MOP_SH   = 5;
    localparam int MOP_SW   = 6;

    typedef struct packed {
        logic [31:0] wdata;
        logic [4:0]  waddr;
        logic        we;
        logic [2:0]  mop;
        logic [31:0] maddr;
        logic [31:0] msdata;
    } ex_mem_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer on a packed payload of W bits.
//   clk, rst (sync, active-high), flush : drop every held and incoming entry
//   in_valid/in_ready/in_data    : upstream side; in_ready is a register (!skid_valid)
//   out_valid/out_ready/out_data : downstream side; out_valid is a register (main_valid)
// The main entry always holds the oldest item; the skid entry only fills
// while main is stalled, so ordering is strict FIFO.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] main_q, skid_q;
    logic         main_v, skid_v;
    logic         acc, drn;

    assign in_ready  = !skid_v;
    assign out_valid = main_v;
    assign out_data  = main_q;
    assign acc       = in_valid && !skid_v;
    assign drn       = main_v && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (flush) begin
            // Payload left stale on purpose; consumers gate on the valid bits.
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (skid_v) begin
            // in_ready is low here, so nothing new can arrive this cycle.
            if (drn) begin
                main_q <= skid_q;
                main_v <= 1'b1;
                skid_v <= 1'b0;
            end
        end else if (!main_v || drn) begin
            if (acc) main_q <= in_data;
            main_v <= acc;
        end else begin
            if (acc) skid_q <= in_data;
            skid_v <= acc;
        end
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with valid/ready handshake and 2-entry skid.
//   clk, rst (sync, active-high), flush
//   in_valid/in_ready + ex_* : entry from EX (writeback + memory-access fields)
//   out_valid/out_ready + mem_* : entry to MEM; mem_we/mem_mop are forced
//                                 inactive whenever out_valid is low
//   bp_cycles : saturating count of cycles with out_valid & !out_ready
module ex_mem_pipe
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int MOP_W   = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  ex_wdata,
    input  logic [RADDR_W-1:0] ex_waddr,
    input  logic               ex_we,
    input  logic [MOP_W-1:0]   ex_mop,
    input  logic [DATA_W-1:0]  ex_maddr,
    input  logic [DATA_W-1:0]  ex_msdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [RADDR_W-1:0] mem_waddr,
    output logic               mem_we,
    output logic [MOP_W-1:0]   mem_mop,
    output logic [DATA_W-1:0]  mem_maddr,
    output logic [DATA_W-1:0]  mem_msdata,
    output logic [CNT_W-1:0]   bp_cycles
);

    // Same field order as ex_mem_payload_t, sized by this instance's parameters.
    typedef struct packed {
        logic [DATA_W-1:0]  wdata;
        logic [RADDR_W-1:0] waddr;
        logic               we;
        logic [MOP_W-1:0]   mop;
        logic [DATA_W-1:0]  maddr;
        logic [DATA_W-1:0]  msdata;
    } payload_t;

    payload_t in_p, out_p;

    assign in_p = '{wdata: ex_wdata, waddr: ex_waddr, we: ex_we, mop: ex_mop,
                    maddr: ex_maddr, msdata: ex_msdata};

    pipe_skid_buf #(.W($bits(payload_t))) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_p)
    );

    assign mem_wdata  = out_p.wdata;
    assign mem_waddr  = out_p.waddr;
    assign mem_maddr  = out_p.maddr;
    assign mem_msdata = out_p.msdata;
    // Stale payload after a flush must never look like a live write or access.
    assign mem_we     = out_p.we && out_valid;
    assign mem_mop    = out_valid ? out_p.mop : MOP_W'(MOP_NONE);

    always_ff @(posedge clk) begin
        if (rst)
            bp_cycles <= '0;
        else if (out_valid && !out_ready && (bp_cycles != '1))
            bp_cycles <= bp_cycles + 1'b1;
    end

endmodule

// File: tb/tb_ex_mem_pipe.sv
module tb_ex_mem_pipe;

    localparam int DATA_W = 32, RADDR_W = 5, MOP_W = 3, CNT_W = 4;

    logic               clk = 1'b0;
    logic               rst, flush, in_valid, in_ready, ex_we, out_valid, out_ready, mem_we;
    logic [DATA_W-1:0]  ex_wdata, ex_maddr, ex_msdata, mem_wdata, mem_maddr, mem_msdata;
    logic [RADDR_W-1:0] ex_waddr, mem_waddr;
    logic [MOP_W-1:0]   ex_mop, mem_mop;
    logic [CNT_W-1:0]   bp_cycles;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_mem_pipe #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .MOP_W(MOP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .ex_wdata(ex_wdata), .ex_waddr(ex_waddr), .ex_we(ex_we), .ex_mop(ex_mop),
        .ex_maddr(ex_maddr), .ex_msdata(ex_msdata), .out_valid(out_valid),
        .out_ready(out_ready), .mem_wdata(mem_wdata), .mem_waddr(mem_waddr),
        .mem_we(mem_we), .mem_mop(mem_mop), .mem_maddr(mem_maddr),
        .mem_msdata(mem_msdata), .bp_cycles(bp_cycles)
    );

    // Inputs applied before a rising edge, expected outputs after that edge.
    typedef struct {
        logic               r, f, iv, we;
        logic [DATA_W-1:0]  wd;
        logic [RADDR_W-1:0] wa;
        logic [MOP_W-1:0]   mop;
        logic               ordy;
        logic               e_ov, e_ir, e_we;
        logic [DATA_W-1:0]  e_wd;
        logic [RADDR_W-1:0] e_wa;
        logic [MOP_W-1:0]   e_mop;
        logic [CNT_W-1:0]   e_bp;
        logic               chk_pay;   // compare payload even when out_valid=0
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, f, iv, we, input logic [31:0] wd, input int wa, mop,
                       input logic ordy, e_ov, e_ir, e_we, input logic [31:0] e_wd,
                       input int e_wa, e_mop, e_bp, input logic chk);
        vec_t v;
        v.r = r; v.f = f; v.iv = iv; v.we = we; v.wd = wd;
        v.wa = RADDR_W'(wa); v.mop = MOP_W'(mop); v.ordy = ordy;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_we = e_we; v.e_wd = e_wd;
        v.e_wa = RADDR_W'(e_wa); v.e_mop = MOP_W'(e_mop); v.e_bp = CNT_W'(e_bp);
        v.chk_pay = chk;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, f, iv, we, input logic [31:0] wd,
                         input logic [RADDR_W-1:0] wa, input logic [MOP_W-1:0] mop,
                         input logic ordy);
        rst = r; flush = f; in_valid = iv; ex_we = we; ex_wdata = wd;
        ex_waddr = wa; ex_mop = mop; ex_maddr = wd + 32'h1000; ex_msdata = ~wd;
        out_ready = ordy;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);

        //   r f iv we wd        wa mop rdy  ov ir we e_wd      wa mop bp chk
        // reset and idle
        add(1,0,0,0, 32'h0,    0, 0, 0,   0,1,0, 32'h0,    0, 0, 0, 1);
        add(1,0,0,0, 32'h0,    0, 0, 0,   0,1,0, 32'h0,    0, 0, 0, 1);
        add(0,0,0,0, 32'h0,    0, 0, 1,   0,1,0, 32'h0,    0, 0, 0, 1);
        // full-rate stream A1..A4, A3 without writeback
        add(0,0,1,1, 32'h11,   1, 1, 1,   1,1,1, 32'h11,   1, 1, 0, 0);
        add(0,0,1,1, 32'h22,   2, 2, 1,   1,1,1, 32'h22,   2, 2, 0, 0);
        add(0,0,1,0, 32'h33,   3, 3, 1,   1,1,0, 32'h33,   3, 3, 0, 0);
        add(0,0,1,1, 32'h44,   4, 4, 1,   1,1,1, 32'h44,   4, 4, 0, 0);
        add(0,0,0,0, 32'h0,    0, 0, 1,   0,1,0, 32'h0,    0, 0, 0, 0);
        // stall: B1 main, B2 skid, B3 held off, then drain in order
        add(0,0,1,1, 32'h55,   5, 1, 0,   1,1,1, 32'h55,   5, 1, 0, 0);
        add(0,0,1,1, 32'h66,   6, 2, 0,   1,0,1, 32'h55,   5, 1, 1, 0);
        add(0,0,1,1, 32'h77,   7, 3, 0,   1,0,1, 32'h55,   5, 1, 2, 0);
        add(0,0,1,1, 32'h77,   7, 3, 1,   1,1,1, 32'h66,   6, 2, 2, 0);
        add(0,0,1,1, 32'h77,   7, 3, 1,   1,1,1, 32'h77,   7, 3, 2, 0);
        add(0,0,0,0, 32'h0,    0, 0, 1,   0,1,0, 32'h0,    0, 0, 2, 0);
        // flush with main+skid full and C9 offered
        add(0,0,1,1, 32'h81,   8, 1, 0,   1,1,1, 32'h81,   8, 1, 2, 0);
        add(0,0,1,1, 32'h82,   9, 2, 0,   1,0,1, 32'h81,   8, 1, 3, 0);
        add(0,1,1,1, 32'h99,  31, 5, 0,   0,1,0, 32'h0,    0, 0, 4, 0);
        add(0,0,0,0, 32'h0,    0, 0, 1,   0,1,0, 32'h0,    0, 0, 4, 0);
        add(0,0,0,0, 32'h0,    0, 0, 1,   0,1,0, 32'h0,    0, 0, 4, 0);
        // reset with main+skid full and D3 offered
        add(0,0,1,1, 32'hA1,  10, 1, 0,   1,1,1, 32'hA1,  10, 1, 4, 0);
        add(0,0,1,1, 32'hA2,  11, 2, 0,   1,0,1, 32'hA1,  10, 1, 5, 0);
        add(1,0,1,1, 32'hA3,  12, 3, 0,   0,1,0, 32'h0,    0, 0, 0, 1);
        add(0,0,0,0, 32'h0,    0, 0, 1,   0,1,0, 32'h0,    0, 0, 0, 1);
        add(0,0,0,0, 32'h0,    0, 0, 1,   0,1,0, 32'h0,    0, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].f, vecs[i].iv, vecs[i].we, vecs[i].wd,
                  vecs[i].wa, vecs[i].mop, vecs[i].ordy);
            @(posedge clk); #1;
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("v%0d in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
            chk($sformatf("v%0d mem_we", i),    32'(mem_we),    32'(vecs[i].e_we));
            chk($sformatf("v%0d mem_mop", i),   32'(mem_mop),   32'(vecs[i].e_mop));
            chk($sformatf("v%0d bp_cycles", i), 32'(bp_cycles), 32'(vecs[i].e_bp));
            if (vecs[i].e_ov || vecs[i].chk_pay) begin
                chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wd);
                chk($sformatf("v%0d mem_waddr", i), 32'(mem_waddr), 32'(vecs[i].e_wa));
            end
            if (vecs[i].e_ov) begin
                chk($sformatf("v%0d mem_maddr", i),  mem_maddr,  vecs[i].e_wd + 32'h1000);
                chk($sformatf("v%0d mem_msdata", i), mem_msdata, ~vecs[i].e_wd);
            end
        end

        // bp_cycles saturation: E1 held with out_ready=0 for 20 cycles
        drive(0, 0, 1, 1, 32'hE1, 13, 1, 0);
        @(posedge clk); #1;
        chk("sat load out_valid", 32'(out_valid), 32'd1);
        chk("sat load bp", 32'(bp_cycles), 32'd0);
        drive(0, 0, 0, 0, 32'h0, 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            chk($sformatf("sat bp k=%0d", k), 32'(bp_cycles), (k > 15) ? 32'd15 : 32'(k));
        end
        chk("sat mem_wdata held", mem_wdata, 32'hE1);
        drive(0, 1, 0, 0, 32'h0, 0, 0, 0);
        @(posedge clk); #1;
        chk("sat flush out_valid", 32'(out_valid), 32'd0);
        chk("sat flush bp kept", 32'(bp_cycles), 32'd15);
        drive(0, 0, 0, 0, 32'h0, 0, 0, 1);
        @(posedge clk); #1;
        chk("sat post-flush bp", 32'(bp_cycles), 32'd15);
        drive(1, 0, 0, 0, 32'h0, 0, 0, 1);
        @(posedge clk); #1;
        chk("sat rst bp", 32'(bp_cycles), 32'd0);
        chk("sat rst in_ready", 32'(in_ready), 32'd1);
        drive(0, 0, 0, 0, 32'h0, 0, 0, 1);
        @(posedge clk); #1;
        chk("sat idle out_valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
